// File: rtl/pulse_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_gen_if : request/status bundle between a controller and        |
// |                pulse_gen.  Revision 1.0                              |
// +----------------------------------------------------------------------+
interface pulse_gen_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] n_pulses;
  logic             pulse;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output start, stop, high_len, low_len, n_pulses,
    input  pulse, busy, done, pulse_cnt
  );

  modport slave (
    input  start, stop, high_len, low_len, n_pulses,
    output pulse, busy, done, pulse_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_gen : burst pulse-train generator (IDLE/HIGH/LOW/DONE FSM).    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module pulse_gen #(
  parameter int CNT_W = 4,
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rstn,
  pulse_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] h_len;
  logic [CNT_W-1:0] l_len;
  logic [CNT_W-1:0] eff_cnt;
  logic [CNT_W-1:0] timer;

  logic             start_ok;
  logic [CNT_W-1:0] h_in;
  logic [CNT_W-1:0] l_in;
  logic [CNT_W-1:0] n_in;

  // Zero lengths behave as one cycle; burst size is clamped to DEPTH.
  assign start_ok = bus.start && !bus.stop && (bus.n_pulses != '0);
  assign h_in     = (bus.high_len == '0) ? ONE_C : bus.high_len;
  assign l_in     = (bus.low_len  == '0) ? ONE_C : bus.low_len;
  assign n_in     = (bus.n_pulses > DEPTH_C) ? DEPTH_C : bus.n_pulses;

  // timer counts down from length-1 to 0, so a length of 2**CNT_W-1 never wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      h_len         <= '0;
      l_len         <= '0;
      eff_cnt       <= '0;
      timer         <= '0;
      bus.pulse     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pulse_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (start_ok) begin
            h_len         <= h_in;
            l_len         <= l_in;
            eff_cnt       <= n_in;
            timer         <= h_in - ONE_C;
            bus.pulse_cnt <= ONE_C;
            bus.pulse     <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= HIGH;
          end
        end

        HIGH: begin
          if (bus.stop) begin
            bus.pulse <= 1'b0;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end else if (timer != '0) begin
            timer <= timer - ONE_C;
          end else if (bus.pulse_cnt < eff_cnt) begin
            timer     <= l_len - ONE_C;
            bus.pulse <= 1'b0;
            state     <= LOW;
          end else begin
            bus.pulse <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= DONE;
          end
        end

        LOW: begin
          if (bus.stop) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (timer != '0) begin
            timer <= timer - ONE_C;
          end else begin
            timer         <= h_len - ONE_C;
            bus.pulse_cnt <= bus.pulse_cnt + ONE_C;
            bus.pulse     <= 1'b1;
            state         <= HIGH;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.pulse <= 1'b0;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pulse_gen : self-checking bench for pulse_gen.  Revision 1.0      |
// +----------------------------------------------------------------------+
module tb_pulse_gen;
  localparam int CNT_W = 4;
  localparam int DEPTH = 3;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  pulse_gen_if #(.CNT_W(CNT_W)) bus ();

  pulse_gen #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: position k inside the burst decides every output.
  int   m_mode;  // 0 idle, 1 running, 2 done strobe
  int   k, mh, ml, mn, mtot;
  logic e_pulse, e_busy, e_done;
  int   e_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = 0; e_pulse = 0; e_busy = 0; e_done = 0; e_cnt = 0;
    end else begin
      case (m_mode)
        0: if (bus.start && !bus.stop && bus.n_pulses != 0) begin
          mh   = (bus.high_len == 0) ? 1 : int'(bus.high_len);
          ml   = (bus.low_len  == 0) ? 1 : int'(bus.low_len);
          mn   = (bus.n_pulses > DEPTH) ? DEPTH : int'(bus.n_pulses);
          mtot = mn * mh + (mn - 1) * ml;
          k    = 0;
          m_mode = 1;
        end
        1: if (bus.stop) m_mode = 0;
           else begin
             k++;
             if (k == mtot) m_mode = 2;
           end
        default: m_mode = 0;
      endcase
      e_pulse = 0; e_busy = 0; e_done = 0;
      if (m_mode == 1) begin
        e_pulse = (k % (mh + ml)) < mh;
        e_busy  = 1;
        e_cnt   = k / (mh + ml) + 1;
      end else if (m_mode == 2) begin
        e_done = 1;
        e_cnt  = mn;
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("model_pulse", int'(bus.pulse), int'(e_pulse));
      chk("model_busy",  int'(bus.busy),  int'(e_busy));
      chk("model_done",  int'(bus.done),  int'(e_done));
      chk("model_cnt",   int'(bus.pulse_cnt), e_cnt);
    end
  end

  task automatic go(input int h, input int l, input int n);
    bus.high_len = CNT_W'(h);
    bus.low_len  = CNT_W'(l);
    bus.n_pulses = CNT_W'(n);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Samples n cycles; first sample is the current negedge, oldest sample ends up in the MSB.
  task automatic capture(input int n, output logic [127:0] tr, output int busy_n, output int done_at);
    tr = '0; busy_n = 0; done_at = -1;
    for (int i = 0; i < n; i++) begin
      tr = {tr[126:0], bus.pulse};
      if (bus.busy) busy_n++;
      if (bus.done && done_at < 0) done_at = i;
      @(negedge clk);
    end
  endtask

  logic [127:0] tr;
  int           bn, da;

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0;
    bus.start = 0; bus.stop = 0; bus.high_len = 0; bus.low_len = 0; bus.n_pulses = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_pulse", int'(bus.pulse), 0);
    chk("reset_busy",  int'(bus.busy), 0);
    chk("reset_done",  int'(bus.done), 0);
    chk("reset_cnt",   int'(bus.pulse_cnt), 0);

    // H=2 L=3 N=2
    go(2, 3, 2);
    capture(9, tr, bn, da);
    chk("basic_trace", int'(tr[8:0]), int'(9'b110001100));
    chk("basic_busy", bn, 7);
    chk("basic_done_at", da, 7);
    chk("basic_cnt", int'(bus.pulse_cnt), 2);

    // N clamped to DEPTH
    go(1, 1, 9);
    capture(7, tr, bn, da);
    chk("clamp_trace", int'(tr[6:0]), int'(7'b1010100));
    chk("clamp_busy", bn, 5);
    chk("clamp_cnt", int'(bus.pulse_cnt), 3);

    // N=0 does nothing
    go(2, 2, 0);
    capture(3, tr, bn, da);
    chk("zero_n_busy", bn, 0);
    chk("zero_n_cnt", int'(bus.pulse_cnt), 3);

    // zero lengths act as 1
    go(0, 0, 3);
    capture(7, tr, bn, da);
    chk("zero_len_trace", int'(tr[6:0]), int'(7'b1010100));
    chk("zero_len_busy", bn, 5);

    // interference: start toggling and input changes during burst, stop during DONE
    go(2, 3, 2);
    tr = '0; bn = 0; da = -1;
    for (int i = 0; i < 9; i++) begin
      tr = {tr[126:0], bus.pulse};
      if (bus.busy) bn++;
      if (bus.done && da < 0) da = i;
      bus.start    = (i <= 7) ? ((i % 2) == 1 || i == 7) : 1'b0;
      bus.stop     = (i == 7);
      bus.high_len = CNT_W'($urandom_range(15, 0));
      bus.low_len  = CNT_W'($urandom_range(15, 0));
      bus.n_pulses = CNT_W'($urandom_range(15, 1));
      @(negedge clk);
      if (i == 7) begin bus.start = 0; bus.stop = 0; end
    end
    bus.start = 0; bus.stop = 0;
    chk("interf_trace", int'(tr[8:0]), int'(9'b110001100));
    chk("interf_busy", bn, 7);
    chk("interf_done_at", da, 7);

    // start+stop in IDLE
    bus.n_pulses = 2; bus.start = 1; bus.stop = 1;
    @(negedge clk);
    bus.start = 0; bus.stop = 0;
    capture(3, tr, bn, da);
    chk("startstop_busy", bn, 0);

    // abort in 2nd cycle of 2nd LOW
    go(4, 4, 3);
    repeat (13) @(negedge clk);
    bus.stop = 1;
    @(negedge clk);
    bus.stop = 0;
    chk("abort_pulse", int'(bus.pulse), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_cnt", int'(bus.pulse_cnt), 2);
    capture(4, tr, bn, da);
    chk("abort_no_done", da, -1);
    go(1, 1, 1);
    capture(3, tr, bn, da);
    chk("after_abort_trace", int'(tr[2:0]), int'(3'b100));
    chk("after_abort_done_at", da, 1);
    chk("after_abort_cnt", int'(bus.pulse_cnt), 1);

    // maximum lengths
    go(15, 15, 3);
    capture(80, tr, bn, da);
    chk("max_busy", bn, 75);
    chk("max_done_at", da, 75);
    chk("max_cnt", int'(bus.pulse_cnt), 3);

    // async reset between edges while HIGH
    go(3, 3, 2);
    @(posedge clk);
    #2;
    chk("pre_rst_pulse", int'(bus.pulse), 1);
    rstn = 1'b0;
    #1;
    chk("async_pulse", int'(bus.pulse), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_cnt", int'(bus.pulse_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    capture(3, tr, bn, da);
    chk("post_rst_no_done", da, -1);
    go(2, 1, 1);
    capture(4, tr, bn, da);
    chk("post_rst_trace", int'(tr[3:0]), int'(4'b1100));
    chk("post_rst_done_at", da, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 The module SHALL have parameter CNT_W, default 4, giving the width of the length and count fields.
REQ-002 The module SHALL have parameter DEPTH, default 3, giving the maximum number of pulses per burst (1..2**CNT_W-1).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: burst request, sampled only in IDLE.
REQ-006 The module SHALL have port stop, input, 1 bit: synchronous abort of the current burst.
REQ-007 The module SHALL have port high_len, input, CNT_W bits: number of cycles pulse is high per pulse.
REQ-008 The module SHALL have port low_len, input, CNT_W bits: number of cycles pulse is low between pulses.
REQ-009 The module SHALL have port n_pulses, input, CNT_W bits: requested pulses per burst.
REQ-010 The module SHALL have port pulse, output, 1 bit: the generated pulse train, registered, feeding a downstream pulse input.
REQ-011 The module SHALL have port busy, output, 1 bit: high while a burst is in progress (states HIGH and LOW).
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle strobe at normal burst completion.
REQ-013 The module SHALL have port pulse_cnt, output, CNT_W bits: number of pulses started in the current or last burst.

Function
REQ-014 The FSM SHALL have states IDLE, HIGH, LOW and DONE.
REQ-015 In IDLE, when start=1, stop=0 and n_pulses!=0, the FSM SHALL latch high_len, low_len and the effective count, then enter HIGH on the next edge.
REQ-016 The effective count SHALL be min(n_pulses, DEPTH).
REQ-017 When start=1 and n_pulses=0, the FSM SHALL remain in IDLE with no output change.
REQ-018 A latched high_len or low_len of 0 SHALL be treated as 1.
REQ-019 pulse SHALL be 1 exactly in HIGH; each HIGH visit SHALL last the latched high length in cycles.
REQ-020 On entering HIGH, pulse_cnt SHALL increment; pulse_cnt SHALL be cleared to 0 on each accepted start.
REQ-021 At the end of HIGH, the FSM SHALL enter LOW if pulse_cnt < effective count, else DONE.
REQ-022 LOW SHALL last the latched low length in cycles, then the FSM SHALL return to HIGH.
REQ-023 DONE SHALL last one cycle with done=1 and pulse=0, then the FSM SHALL return to IDLE.
REQ-024 Latency SHALL be: first pulse rising edge one cycle after the start edge; total burst = N*H + (N-1)*L cycles of busy=1.
REQ-025 Input changes on high_len, low_len and n_pulses during a burst SHALL have no effect.
REQ-026 start asserted while not in IDLE, including in DONE, SHALL be ignored and not queued.
REQ-027 stop=1 in HIGH or LOW SHALL move the FSM to IDLE on the next edge with pulse=0 and busy=0, done not asserted, and pulse_cnt holding its value.
REQ-028 stop=1 together with start=1 in IDLE SHALL take priority: start is ignored.
REQ-029 stop in DONE SHALL have no effect; done still strobes.
REQ-030 Internal cycle counters SHALL be CNT_W bits and SHALL never wrap; high_len and low_len = 2**CNT_W-1 SHALL be supported exactly.

Reset
REQ-031 rstn=0 SHALL immediately, without waiting for a clock edge, force state IDLE, pulse=0, busy=0, done=0, pulse_cnt=0, and clear the latched lengths and count.
REQ-032 Reset asserted mid-burst SHALL abort the burst with no done strobe; after rstn rises, the first accepted start SHALL need a clock edge with rstn=1.
REQ-033 All outputs SHALL be driven from registers; no combinational path from inputs to outputs.

Verification
REQ-034 Defaults (CNT_W=4, DEPTH=3): start with H=2, L=3, N=2 -> pulse high for 2 cycles, low for 3, high for 2; busy=1 for 7 cycles; done=1 in the 8th cycle; pulse_cnt=2.
REQ-035 Clamp and zero: N=9 -> exactly 3 pulses, pulse_cnt=3; N=0 -> no activity; H=0, L=0, N=3 -> 1-high/1-low alternation of 5 cycles.
REQ-036 Abort: H=4, L=4, N=3 with stop in the 2nd cycle of the second LOW -> pulse=0 and busy=0 next cycle, done never asserted, pulse_cnt=2; start is then accepted normally.
REQ-037 Interference: during a burst, toggle start and change H/L/N -> burst timing unchanged; start+stop together in IDLE -> no burst.
REQ-038 Async reset: assert rstn low between clock edges in HIGH -> pulse, busy and pulse_cnt go 0 before the next edge.
REQ-039 Maximum length: H=15, L=15, N=3 -> busy exactly 75 cycles, no counter wrap.
